// File: rtl/piso_sched.sv
// Round-robin scheduler and frame sequencer for the 32-bit serial transmitter.
// Grants one requester word at a time and drives piso load/xmit through load -> shift -> gap.
module piso_sched #(
    parameter int N_REQ       = 4,
    parameter int XMIT_CYCLES = 64,
    parameter int GAP_CYCLES  = 4,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [ID_W-1:0]      active_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 piso_load,
    output logic                 piso_xmit,
    output logic [31:0]          piso_data
);

    localparam int CNT_W = $clog2(XMIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XMIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;

    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [ID_W-1:0]  active_id_reg, active_id_next;
    logic             busy_reg, busy_next;
    logic             frame_done_reg, frame_done_next;
    logic             piso_load_reg, piso_load_next;
    logic             piso_xmit_reg, piso_xmit_next;
    logic [31:0]      piso_data_reg, piso_data_next;

    // Requester index examined at each offset from rr_ptr, and whether it is requesting.
    logic [ID_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0] req_hit;
    logic [31:0]      req_word [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rr
            logic [ID_W:0] sum;
            assign sum           = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                             : ID_W'(sum);
            assign req_hit[gi]   = req[cand_idx[gi]];
            assign req_word[gi]  = req_data[32*gi +: 32];
        end
    endgenerate

    logic [ID_W-1:0] win_idx;
    logic            grant;

    // Lowest offset from rr_ptr wins, so iterate downward and let it overwrite.
    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_hit[i]) begin
                win_idx = cand_idx[i];
            end
        end
    end

    assign grant = (state_reg == IDLE) && enable && (|req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            rr_ptr_reg     <= '0;
            gnt_reg        <= '0;
            active_id_reg  <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            piso_load_reg  <= 1'b0;
            piso_xmit_reg  <= 1'b0;
            piso_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rr_ptr_reg     <= rr_ptr_next;
            gnt_reg        <= gnt_next;
            active_id_reg  <= active_id_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            piso_load_reg  <= piso_load_next;
            piso_xmit_reg  <= piso_xmit_next;
            piso_data_reg  <= piso_data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (grant) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_next   = '0;
                state_next = XMIT;
            end
            XMIT: begin
                if (cnt_reg == CNT_W'(XMIT_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        gnt_next        = '0;
        active_id_next  = active_id_reg;
        piso_data_next  = piso_data_reg;
        rr_ptr_next     = rr_ptr_reg;
        if (grant) begin
            gnt_next[win_idx] = 1'b1;
            active_id_next    = win_idx;
            piso_data_next    = req_word[win_idx];
            rr_ptr_next       = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        busy_next       = (state_next != IDLE);
        piso_load_next  = (state_next == LOAD);
        piso_xmit_next  = (state_next == XMIT);
        frame_done_next = (state_reg == XMIT) && (state_next == GAP);
    end

    assign gnt        = gnt_reg;
    assign active_id  = active_id_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign piso_load  = piso_load_reg;
    assign piso_xmit  = piso_xmit_reg;
    assign piso_data  = piso_data_reg;

endmodule
